// File: rtl/rgb_frame_fetch.sv
// Fetches the packed RGB frame from SRAM (three words per pixel pair) and streams
// 24-bit pixels through a small first-word-fall-through FIFO with valid/ready.
//
// state    | meaning
// S_IDLE   | waiting for Enable
// S_WAIT   | frame active, waiting for FIFO credit to issue the next pair
// S_ISSUE0 | drive address of word {R0,G0}
// S_ISSUE1 | drive address of word {B0,R1}
// S_ISSUE2 | drive address of word {G1,B1}, optionally chain the next pair
// S_DRAIN  | all reads issued, waiting for the last pixel to be accepted
module rgb_frame_fetch #(
    parameter logic [17:0] RGB_BASE   = 18'd146944,
    parameter logic [16:0] NUM_PIXELS = 17'd76800,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Enable,
    output logic [17:0] SRAM_address,
    input  logic [15:0] SRAM_read_data,
    output logic        SRAM_we_n,
    output logic        pixel_valid,
    input  logic        pixel_ready,
    output logic [7:0]  pixel_R,
    output logic [7:0]  pixel_G,
    output logic [7:0]  pixel_B,
    output logic        pixel_last,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ISSUE0 = 3'd1;
    localparam logic [2:0] S_ISSUE1 = 3'd2;
    localparam logic [2:0] S_ISSUE2 = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_DRAIN  = 3'd5;

    localparam logic [16:0]   NUM_PAIRS = NUM_PIXELS >> 1;
    localparam int            PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int            CW        = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_DEPTH - 1);

    logic [2:0]      state_q, state_d;
    logic [17:0]     word_addr_q, word_addr_d;
    logic [17:0]     sram_addr_q, sram_addr_d;
    logic [16:0]     pair_q, pair_d;
    logic [CW-1:0]   go_q, go_d;
    logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [2:0][3:0] tag_q;
    logic [3:0]      tag_new;
    logic [7:0]      r0_q, g0_q, r1_q;
    logic            busy_q, busy_d, done_q, done_d;
    logic [24:0]     fifo_mem [FIFO_DEPTH];
    logic [24:0]     head, push_data;
    logic [31:0]     reserved;
    logic            ret_v, ret_last;
    logic [1:0]      ret_ph;
    logic            fifo_push, fifo_pop, fifo_full, push_odd, go_inc;
    logic            pairs_remain, issue_ok;

    // Tag stage 2 lines up with the data of the address registered two edges earlier.
    assign ret_v     = tag_q[2][3];
    assign ret_last  = tag_q[2][2];
    assign ret_ph    = tag_q[2][1:0];
    assign fifo_push = ret_v && (ret_ph != 2'd0);
    assign push_odd  = ret_v && (ret_ph == 2'd2);
    assign push_data = push_odd ? {ret_last, r1_q, SRAM_read_data}
                                : {1'b0, r0_q, g0_q, SRAM_read_data[15:8]};

    assign pixel_valid = (fifo_cnt_q != '0);
    assign fifo_full   = (fifo_cnt_q == CW'(FIFO_DEPTH));
    assign fifo_pop    = pixel_valid && pixel_ready;
    assign head        = fifo_mem[rd_ptr_q];

    assign pairs_remain = (pair_q < NUM_PAIRS);
    assign reserved     = 32'(fifo_cnt_q) + (32'(go_q) << 1) + 32'd2;
    assign issue_ok     = pairs_remain && (reserved <= 32'(FIFO_DEPTH));

    always_comb begin
        state_d     = state_q;
        word_addr_d = word_addr_q;
        sram_addr_d = sram_addr_q;
        pair_d      = pair_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        tag_new     = 4'd0;
        go_inc      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Enable) begin
                    word_addr_d = RGB_BASE;
                    pair_d      = '0;
                    busy_d      = 1'b1;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (issue_ok)          state_d = S_ISSUE0;
                else if (!pairs_remain) state_d = S_DRAIN;
            end
            S_ISSUE0: begin
                sram_addr_d = word_addr_q;
                word_addr_d = word_addr_q + 18'd1;
                pair_d      = pair_q + 17'd1;
                go_inc      = 1'b1;
                tag_new     = {1'b1, 1'b0, 2'd0};
                state_d     = S_ISSUE1;
            end
            S_ISSUE1: begin
                sram_addr_d = word_addr_q;
                word_addr_d = word_addr_q + 18'd1;
                tag_new     = {1'b1, 1'b0, 2'd1};
                state_d     = S_ISSUE2;
            end
            S_ISSUE2: begin
                sram_addr_d = word_addr_q;
                word_addr_d = word_addr_q + 18'd1;
                tag_new     = {1'b1, (pair_q == NUM_PAIRS), 2'd2};
                if (issue_ok)          state_d = S_ISSUE0;
                else if (pairs_remain) state_d = S_WAIT;
                else                   state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if ((go_q == '0) && fifo_pop && head[24]) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        go_d = go_q;
        if (go_inc && !push_odd)      go_d = go_q + 1'b1;
        else if (!go_inc && push_odd) go_d = go_q - 1'b1;

        fifo_cnt_d = fifo_cnt_q;
        if (fifo_push && !fifo_pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
        else if (!fifo_push && fifo_pop) fifo_cnt_d = fifo_cnt_q - 1'b1;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= S_IDLE;
            word_addr_q <= '0;
            sram_addr_q <= '0;
            pair_q      <= '0;
            go_q        <= '0;
            fifo_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            tag_q       <= '0;
            r0_q        <= '0;
            g0_q        <= '0;
            r1_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_addr_q <= word_addr_d;
            sram_addr_q <= sram_addr_d;
            pair_q      <= pair_d;
            go_q        <= go_d;
            fifo_cnt_q  <= fifo_cnt_d;
            tag_q       <= {tag_q[1:0], tag_new};
            busy_q      <= busy_d;
            done_q      <= done_d;
            if (ret_v && (ret_ph == 2'd0)) begin
                r0_q <= SRAM_read_data[15:8];
                g0_q <= SRAM_read_data[7:0];
            end
            if (ret_v && (ret_ph == 2'd1)) r1_q <= SRAM_read_data[7:0];
            if (fifo_push) wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            if (fifo_pop)  rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (fifo_push) fifo_mem[wr_ptr_q] <= push_data;
    end

    // Credit accounting reserves a slot for every outstanding pixel, so this must never fire.
    a_no_push_full: assert property (@(posedge Clock) disable iff (!Resetn) !(fifo_push && fifo_full));

    assign SRAM_address = sram_addr_q;
    assign SRAM_we_n    = 1'b1;
    assign pixel_R      = pixel_valid ? head[23:16] : 8'd0;
    assign pixel_G      = pixel_valid ? head[15:8]  : 8'd0;
    assign pixel_B      = pixel_valid ? head[7:0]   : 8'd0;
    assign pixel_last   = pixel_valid ? head[24]    : 1'b0;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_rgb_frame_fetch.sv
// Scoreboard bench for rgb_frame_fetch: a 240-pixel frame placed so its final word
// lands on address 262143, with a 2-cycle-latency SRAM model.
module tb_rgb_frame_fetch;

    localparam logic [17:0] BASE  = 18'd261784;
    localparam logic [16:0] NPIX  = 17'd240;
    localparam int          FD    = 4;
    localparam logic [17:0] LASTA = 18'd262143;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        ready = 1'b0;
    logic [17:0] sram_addr;
    logic [15:0] rd_data;
    logic        we_n, pixel_valid, pixel_last, busy, done;
    logic [7:0]  pix_r, pix_g, pix_b;

    int n_tests = 0;
    int n_fail  = 0;
    int ready_mode = 1;
    int done_cnt = 0;
    int done_base = 0;
    int reads = 0;
    bit expect_restart = 1'b0;
    bit we_low = 1'b0;
    bit done_prev = 1'b0;
    logic [17:0] prev_addr = '0;
    logic [17:0] max_addr = '0;
    logic [17:0] a1 = '0, a2 = '0;
    logic [24:0] exp_q [$];
    logic [23:0] hand_px [4];
    logic [17:0] a_hist [7];
    logic        v_hist [7];

    always #5 clk = ~clk;

    rgb_frame_fetch #(.RGB_BASE(BASE), .NUM_PIXELS(NPIX), .FIFO_DEPTH(FD)) dut (
        .Clock(clk), .Resetn(rst_n), .Enable(enable),
        .SRAM_address(sram_addr), .SRAM_read_data(rd_data), .SRAM_we_n(we_n),
        .pixel_valid(pixel_valid), .pixel_ready(ready),
        .pixel_R(pix_r), .pixel_G(pix_g), .pixel_B(pix_b), .pixel_last(pixel_last),
        .busy(busy), .done(done)
    );

    function automatic logic [15:0] word_at(int off);
        case (off)
            0: return 16'h1122;
            1: return 16'h3344;
            2: return 16'h5566;
            3: return 16'h7788;
            4: return 16'h99AA;
            5: return 16'hBBCC;
            default: return 16'(off * 40503) ^ 16'h5A5A;
        endcase
    endfunction

    always @(posedge clk) begin
        a1 <= sram_addr;
        a2 <= a1;
    end
    always_comb rd_data = (a2 >= BASE) ? word_at(int'(a2 - BASE)) : 16'hDEAD;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_frame();
        logic [15:0] w0, w1, w2;
        logic [23:0] rgb;
        for (int p = 0; p < int'(NPIX); p++) begin
            w0 = word_at(3 * (p / 2));
            w1 = word_at(3 * (p / 2) + 1);
            w2 = word_at(3 * (p / 2) + 2);
            rgb = (p % 2 == 0) ? {w0, w1[15:8]} : {w1[7:0], w2};
            if (p < 4) rgb = hand_px[p];
            exp_q.push_back({(p == int'(NPIX) - 1), rgb});
        end
    endtask

    task automatic start_frame();
        @(posedge clk); #2;
        enable = 1'b1;
        expect_restart = 1'b1;
        done_base = done_cnt;
        reads = 0;
        max_addr = '0;
        @(posedge clk); #1;
        enable = 1'b0;
    endtask

    task automatic wait_done(int budget);
        for (int i = 0; i < budget && done_cnt == done_base; i++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        chk("done_pulses", done_cnt - done_base, 1);
        chk("busy_after_done", busy, 0);
        chk("sb_empty", exp_q.size(), 0);
    endtask

    initial forever begin
        @(posedge clk); #1;
        case (ready_mode)
            0:       ready = 1'b1;
            1:       ready = 1'b0;
            default: ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: pixels against the scoreboard, done/busy relation, address continuity.
    always @(negedge clk) begin
        logic [24:0] e;
        logic [17:0] exp_a;
        if (rst_n) begin
            if (we_n !== 1'b1) we_low = 1'b1;
            if (pixel_valid && ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL pixel_unexpected: got %0h expected none", {pixel_last, pix_r, pix_g, pix_b});
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel", {7'd0, pixel_last, pix_r, pix_g, pix_b}, {7'd0, e});
                end
            end
            if (done) begin
                done_cnt++;
                chk("busy_at_done", busy, 0);
                chk("done_one_cycle", done_prev, 0);
            end
            done_prev = done;
            if (sram_addr != prev_addr) begin
                reads++;
                exp_a = prev_addr + 18'd1;
                if (expect_restart) begin
                    exp_a = BASE;
                    expect_restart = 1'b0;
                end
                chk("addr_seq", sram_addr, exp_a);
                prev_addr = sram_addr;
                if (sram_addr > max_addr) max_addr = sram_addr;
            end
        end else begin
            prev_addr = '0;
            done_prev = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit reached;
        hand_px[0] = 24'h112233;
        hand_px[1] = 24'h445566;
        hand_px[2] = 24'h778899;
        hand_px[3] = 24'hAABBCC;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", sram_addr, 0);
        chk("rst_we_n", we_n, 1);
        chk("rst_valid", pixel_valid, 0);
        chk("rst_last", pixel_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rgb", {pix_r, pix_g, pix_b}, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Frame A: ready held high, latency and address timing
        ready_mode = 0;
        push_frame();
        start_frame();
        chk("busy_after_enable", busy, 1);
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk); #1;
            a_hist[i] = sram_addr;
            v_hist[i] = pixel_valid;
        end
        chk("addr_word0", a_hist[2], BASE);
        chk("addr_word1", a_hist[3], BASE + 18'd1);
        chk("addr_word2", a_hist[4], BASE + 18'd2);
        chk("valid_cycle5", v_hist[5], 0);
        chk("valid_cycle6", v_hist[6], 1);
        wait_done(4000);
        chk("last_addr_a", max_addr, LASTA);

        // Frame B: backpressure, then random ready with an ignored Enable
        ready_mode = 1;
        push_frame();
        start_frame();
        repeat (40) @(posedge clk);
        #1;
        chk("bp_reads", reads, 6);
        chk("bp_addr", sram_addr, BASE + 18'd5);
        chk("bp_valid", pixel_valid, 1);
        chk("bp_head", {pix_r, pix_g, pix_b}, 24'h112233);
        repeat (10) @(posedge clk);
        #1;
        chk("bp_frozen", sram_addr, BASE + 18'd5);
        chk("bp_reads_hold", reads, 6);
        ready_mode = 2;
        repeat (60) @(posedge clk);
        #2;
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        chk("busy_ignore_enable", busy, 1);
        wait_done(6000);
        chk("last_addr_b", max_addr, LASTA);

        // Frame C: asynchronous reset around pair 100
        ready_mode = 2;
        push_frame();
        start_frame();
        reached = 1'b0;
        for (int i = 0; i < 6000 && !reached; i++) begin
            @(posedge clk); #1;
            if (sram_addr >= BASE + 18'd300) reached = 1'b1;
        end
        chk("reach_pair100", reached, 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_addr", sram_addr, 0);
        chk("mid_rst_valid", pixel_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_last", pixel_last, 0);
        chk("mid_rst_rgb", {pix_r, pix_g, pix_b}, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Frame D: restart after reset
        ready_mode = 2;
        push_frame();
        start_frame();
        wait_done(6000);
        chk("last_addr_d", max_addr, LASTA);
        chk("we_n_never_low", we_low, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
